// File: rtl/arf_rename_file.sv
// Architectural register file with RRF rename-tag manager: allocates tags from a
// circular free list, captures CDB results, and retires committed values and tags.
module arf_rename_file #(
    parameter int DATA_W  = 16,
    parameter int TAG_W   = 5,
    parameter int NUM_RRF = 32,
    parameter int NUM_ARF = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_req_0,
    input  logic [2:0]        alloc_arf_0,
    input  logic              alloc_req_1,
    input  logic [2:0]        alloc_arf_1,
    output logic              alloc_gnt,
    output logic [TAG_W-1:0]  alloc_tag_0,
    output logic [TAG_W-1:0]  alloc_tag_1,
    input  logic [2:0]        rd_arf_0,
    input  logic [2:0]        rd_arf_1,
    output logic [DATA_W-1:0] rd_data_0,
    output logic [DATA_W-1:0] rd_data_1,
    output logic [TAG_W-1:0]  rd_tag_0,
    output logic [TAG_W-1:0]  rd_tag_1,
    output logic              rd_ready_0,
    output logic              rd_ready_1,
    input  logic              cdb_valid_0,
    input  logic [TAG_W-1:0]  cdb_tag_0,
    input  logic [DATA_W-1:0] cdb_data_0,
    input  logic              cdb_valid_1,
    input  logic [TAG_W-1:0]  cdb_tag_1,
    input  logic [DATA_W-1:0] cdb_data_1,
    input  logic              arf_valid_0,
    input  logic [2:0]        arf_dest_0,
    input  logic [DATA_W-1:0] arf_value_0,
    input  logic [TAG_W-1:0]  commit_tag_0,
    input  logic              arf_valid_1,
    input  logic [2:0]        arf_dest_1,
    input  logic [DATA_W-1:0] arf_value_1,
    input  logic [TAG_W-1:0]  commit_tag_1,
    output logic [TAG_W:0]    free_count,
    output logic              fl_err
);
    localparam int CNT_W = TAG_W + 1;

    logic [DATA_W-1:0] arf_value_q [NUM_ARF];
    logic [DATA_W-1:0] arf_value_d [NUM_ARF];
    logic              arf_busy_q  [NUM_ARF];
    logic              arf_busy_d  [NUM_ARF];
    logic [TAG_W-1:0]  arf_tag_q   [NUM_ARF];
    logic [TAG_W-1:0]  arf_tag_d   [NUM_ARF];
    logic              rrf_valid_q [NUM_RRF];
    logic              rrf_valid_d [NUM_RRF];
    logic [DATA_W-1:0] rrf_data_q  [NUM_RRF];
    logic [DATA_W-1:0] rrf_data_d  [NUM_RRF];
    logic [TAG_W-1:0]  fl_q        [NUM_RRF];
    logic [TAG_W-1:0]  fl_d        [NUM_RRF];
    logic [TAG_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  free_count_q, free_count_d;
    logic              fl_err_q, fl_err_d;

    logic [1:0]        need;
    logic [TAG_W-1:0]  alloc_idx_1;
    logic              do_alloc;

    // Grant uses only the registered count: tags freed this cycle are not reusable yet.
    assign need        = 2'(alloc_req_0) + 2'(alloc_req_1);
    assign alloc_idx_1 = rd_ptr_q + TAG_W'(alloc_req_0);
    assign alloc_tag_0 = fl_q[rd_ptr_q];
    assign alloc_tag_1 = fl_q[alloc_idx_1];
    assign alloc_gnt   = (CNT_W'(need) <= free_count_q);
    assign do_alloc    = alloc_gnt && (need != 2'd0);
    assign free_count  = free_count_q;
    assign fl_err      = fl_err_q;

    always_comb begin
        arf_value_d  = arf_value_q;
        arf_busy_d   = arf_busy_q;
        arf_tag_d    = arf_tag_q;
        rrf_valid_d  = rrf_valid_q;
        rrf_data_d   = rrf_data_q;
        fl_d         = fl_q;
        fl_err_d     = fl_err_q;
        rd_ptr_d     = do_alloc ? rd_ptr_q + TAG_W'(need) : rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        free_count_d = free_count_q - (do_alloc ? CNT_W'(need) : '0);

        // Port 1 is applied first so port 0 overrides it on a shared tag.
        if (cdb_valid_1) begin
            rrf_data_d[cdb_tag_1]  = cdb_data_1;
            rrf_valid_d[cdb_tag_1] = 1'b1;
        end
        if (cdb_valid_0) begin
            rrf_data_d[cdb_tag_0]  = cdb_data_0;
            rrf_valid_d[cdb_tag_0] = 1'b1;
        end

        if (arf_valid_0) begin
            arf_value_d[arf_dest_0] = arf_value_0;
            if (arf_busy_q[arf_dest_0] && arf_tag_q[arf_dest_0] == commit_tag_0)
                arf_busy_d[arf_dest_0] = 1'b0;
            if (free_count_d == CNT_W'(NUM_RRF)) begin
                fl_err_d = 1'b1;
            end else begin
                fl_d[wr_ptr_d] = commit_tag_0;
                wr_ptr_d       = wr_ptr_d + TAG_W'(1);
                free_count_d   = free_count_d + CNT_W'(1);
            end
        end
        if (arf_valid_1) begin
            arf_value_d[arf_dest_1] = arf_value_1;
            if (arf_busy_q[arf_dest_1] && arf_tag_q[arf_dest_1] == commit_tag_1)
                arf_busy_d[arf_dest_1] = 1'b0;
            if (free_count_d == CNT_W'(NUM_RRF)) begin
                fl_err_d = 1'b1;
            end else begin
                fl_d[wr_ptr_d] = commit_tag_1;
                wr_ptr_d       = wr_ptr_d + TAG_W'(1);
                free_count_d   = free_count_d + CNT_W'(1);
            end
        end

        // Allocation last: its busy/tag and valid-clear take priority over commit and CDB.
        if (do_alloc && alloc_req_0) begin
            arf_busy_d[alloc_arf_0]  = 1'b1;
            arf_tag_d[alloc_arf_0]   = alloc_tag_0;
            rrf_valid_d[alloc_tag_0] = 1'b0;
        end
        if (do_alloc && alloc_req_1) begin
            arf_busy_d[alloc_arf_1]  = 1'b1;
            arf_tag_d[alloc_arf_1]   = alloc_tag_1;
            rrf_valid_d[alloc_tag_1] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ARF; i++) begin
                arf_value_q[i] <= '0;
                arf_busy_q[i]  <= 1'b0;
                arf_tag_q[i]   <= '0;
            end
            for (int i = 0; i < NUM_RRF; i++) begin
                rrf_valid_q[i] <= 1'b0;
                rrf_data_q[i]  <= '0;
                fl_q[i]        <= TAG_W'(i);
            end
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            free_count_q <= CNT_W'(NUM_RRF);
            fl_err_q     <= 1'b0;
        end else begin
            arf_value_q  <= arf_value_d;
            arf_busy_q   <= arf_busy_d;
            arf_tag_q    <= arf_tag_d;
            rrf_valid_q  <= rrf_valid_d;
            rrf_data_q   <= rrf_data_d;
            fl_q         <= fl_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            free_count_q <= free_count_d;
            fl_err_q     <= fl_err_d;
        end
    end

    // Operand lookup sees registered state only; a CDB result shows up one cycle later.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        logic [2:0]        idx;
        logic [DATA_W-1:0] data;
        logic              ready;
        assign idx = (gi == 0) ? rd_arf_0 : rd_arf_1;
        always_comb begin
            data  = '0;
            ready = 1'b0;
            if (!arf_busy_q[idx]) begin
                data  = arf_value_q[idx];
                ready = 1'b1;
            end else if (rrf_valid_q[arf_tag_q[idx]]) begin
                data  = rrf_data_q[arf_tag_q[idx]];
                ready = 1'b1;
            end
        end
    end

    assign rd_data_0  = g_rd[0].data;
    assign rd_data_1  = g_rd[1].data;
    assign rd_ready_0 = g_rd[0].ready;
    assign rd_ready_1 = g_rd[1].ready;
    assign rd_tag_0   = arf_tag_q[rd_arf_0];
    assign rd_tag_1   = arf_tag_q[rd_arf_1];
endmodule

// File: tb/tb_arf_rename_file.sv
// Scenario bench for arf_rename_file: expectations are queued when stimulus is
// applied and popped when the corresponding outputs are sampled.
module tb_arf_rename_file;
    localparam int DW = 16;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_req_0, alloc_req_1, alloc_gnt;
    logic [2:0]    alloc_arf_0, alloc_arf_1;
    logic [TW-1:0] alloc_tag_0, alloc_tag_1;
    logic [2:0]    rd_arf_0, rd_arf_1;
    logic [DW-1:0] rd_data_0, rd_data_1;
    logic [TW-1:0] rd_tag_0, rd_tag_1;
    logic          rd_ready_0, rd_ready_1;
    logic          cdb_valid_0, cdb_valid_1;
    logic [TW-1:0] cdb_tag_0, cdb_tag_1;
    logic [DW-1:0] cdb_data_0, cdb_data_1;
    logic          arf_valid_0, arf_valid_1;
    logic [2:0]    arf_dest_0, arf_dest_1;
    logic [DW-1:0] arf_value_0, arf_value_1;
    logic [TW-1:0] commit_tag_0, commit_tag_1;
    logic [TW:0]   free_count;
    logic          fl_err;

    arf_rename_file dut (
        .clk(clk), .rst(rst),
        .alloc_req_0(alloc_req_0), .alloc_arf_0(alloc_arf_0),
        .alloc_req_1(alloc_req_1), .alloc_arf_1(alloc_arf_1),
        .alloc_gnt(alloc_gnt), .alloc_tag_0(alloc_tag_0), .alloc_tag_1(alloc_tag_1),
        .rd_arf_0(rd_arf_0), .rd_arf_1(rd_arf_1),
        .rd_data_0(rd_data_0), .rd_data_1(rd_data_1),
        .rd_tag_0(rd_tag_0), .rd_tag_1(rd_tag_1),
        .rd_ready_0(rd_ready_0), .rd_ready_1(rd_ready_1),
        .cdb_valid_0(cdb_valid_0), .cdb_tag_0(cdb_tag_0), .cdb_data_0(cdb_data_0),
        .cdb_valid_1(cdb_valid_1), .cdb_tag_1(cdb_tag_1), .cdb_data_1(cdb_data_1),
        .arf_valid_0(arf_valid_0), .arf_dest_0(arf_dest_0),
        .arf_value_0(arf_value_0), .commit_tag_0(commit_tag_0),
        .arf_valid_1(arf_valid_1), .arf_dest_1(arf_dest_1),
        .arf_value_1(arf_value_1), .commit_tag_1(commit_tag_1),
        .free_count(free_count), .fl_err(fl_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   fl_m[$];
    int   checks = 0;
    int   errors = 0;
    int   t3, t5, ta, tb6, tc, td, te, tf, tx;

    task automatic exp_push(input string n, input int v);
        sb.push_back('{name: n, val: 32'(v)});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in;
        alloc_req_0 = 0; alloc_arf_0 = 0; alloc_req_1 = 0; alloc_arf_1 = 0;
        rd_arf_0 = 0; rd_arf_1 = 0;
        cdb_valid_0 = 0; cdb_tag_0 = 0; cdb_data_0 = 0;
        cdb_valid_1 = 0; cdb_tag_1 = 0; cdb_data_1 = 0;
        arf_valid_0 = 0; arf_dest_0 = 0; arf_value_0 = 0; commit_tag_0 = 0;
        arf_valid_1 = 0; arf_dest_1 = 0; arf_value_1 = 0; commit_tag_1 = 0;
    endtask

    task automatic model_reset;
        fl_m.delete();
        for (int i = 0; i < 32; i++) fl_m.push_back(i);
    endtask

    task automatic test_reset;
        clear_in();
        rst = 1;
        repeat (2) @(posedge clk);
        #1; rst = 0;
        model_reset();
        rd_arf_0 = 3;
        exp_push("rst_count", 32); exp_push("rst_err", 0); exp_push("rst_gnt", 1);
        exp_push("rst_tag0", 0); exp_push("rst_ready", 1); exp_push("rst_data", 0);
        #3;
        e = sb.pop_front(); checks++; if (32'(free_count) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, free_count, e.val); end
        e = sb.pop_front(); checks++; if (32'(fl_err) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, fl_err, e.val); end
        e = sb.pop_front(); checks++; if (32'(alloc_gnt) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, alloc_gnt, e.val); end
        e = sb.pop_front(); checks++; if (32'(alloc_tag_0) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, alloc_tag_0, e.val); end
        e = sb.pop_front(); checks++; if (32'(rd_ready_0) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, rd_ready_0, e.val); end
        e = sb.pop_front(); checks++; if (32'(rd_data_0) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, rd_data_0, e.val); end
        tick();
        $display("test_reset done");
    endtask

    task automatic test_alloc_dual;
        alloc_req_0 = 1; alloc_arf_0 = 3; alloc_req_1 = 1; alloc_arf_1 = 5;
        t3 = fl_m[0]; t5 = fl_m[1];
        exp_push("dual_gnt", 1); exp_push("dual_tag0", t3); exp_push("dual_tag1", t5);
        #3;
        e = sb.pop_front(); checks++; if (32'(alloc_gnt) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, alloc_gnt, e.val); end
        e = sb.pop_front(); checks++; if (32'(alloc_tag_0) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, alloc_tag_0, e.val); end
        e = sb.pop_front(); checks++; if (32'(alloc_tag_1) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, alloc_tag_1, e.val); end
        tick();
        void'(fl_m.pop_front()); void'(fl_m.pop_front());
        clear_in(); rd_arf_0 = 3; rd_arf_1 = 5;
        exp_push("dual_count", fl_m.size()); exp_push("dual_ready0", 0); exp_push("dual_rdtag0", t3);
        exp_push("dual_ready1", 0); exp_push("dual_rdtag1", t5);
        #3;
        e = sb.pop_front(); checks++; if (32'(free_count) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, free_count, e.val); end
        e = sb.pop_front(); checks++; if (32'(rd_ready_0) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, rd_ready_0, e.val); end
        e = sb.pop_front(); checks++; if (32'(rd_tag_0) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, rd_tag_0, e.val); end
        e = sb.pop_front(); checks++; if (32'(rd_ready_1) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, rd_ready_1, e.val); end
        e = sb.pop_front(); checks++; if (32'(rd_tag_1) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, rd_tag_1, e.val); end
        tick();
        $display("test_alloc_dual tags %0d %0d", t3, t5);
    endtask

    task automatic test_cdb;
        clear_in();
        cdb_valid_0 = 1; cdb_tag_0 = TW'(t3); cdb_data_0 = 16'h1234; rd_arf_0 = 3;
        exp_push("cdb_same_cycle_ready", 0);
        #3;
        e = sb.pop_front(); checks++; if (32'(rd_ready_0) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, rd_ready_0, e.val); end
        tick();
        clear_in(); rd_arf_0 = 3;
        exp_push("cdb_next_ready", 1); exp_push("cdb_next_data", 16'h1234);
        #3;
        e = sb.pop_front(); checks++; if (32'(rd_ready_0) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, rd_ready_0, e.val); end
        e = sb.pop_front(); checks++; if (32'(rd_data_0) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, rd_data_0, e.val); end
        tick();
        clear_in();
        cdb_valid_0 = 1; cdb_tag_0 = TW'(t5); cdb_data_0 = 16'haaaa;
        cdb_valid_1 = 1; cdb_tag_1 = TW'(t5); cdb_data_1 = 16'hbbbb;
        tick();
        clear_in(); rd_arf_1 = 5;
        exp_push("cdb_port0_wins", 16'haaaa);
        #3;
        e = sb.pop_front(); checks++; if (32'(rd_data_1) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, rd_data_1, e.val); end
        tick();
        $display("test_cdb done");
    endtask

    task automatic test_commit;
        clear_in();
        arf_valid_0 = 1; arf_dest_0 = 3; arf_value_0 = 16'h1234; commit_tag_0 = TW'(t3);
        fl_m.push_back(t3);
        exp_push("commit_count", fl_m.size());
        tick();
        clear_in();
        #3;
        e = sb.pop_front(); checks++; if (32'(free_count) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, free_count, e.val); end
        tick();
        // A late write to the retired tag must not affect the now-idle register.
        cdb_valid_0 = 1; cdb_tag_0 = TW'(t3); cdb_data_0 = 16'h9999;
        tick();
        clear_in(); rd_arf_0 = 3;
        exp_push("commit_ready", 1); exp_push("commit_arf_value", 16'h1234);
        #3;
        e = sb.pop_front(); checks++; if (32'(rd_ready_0) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, rd_ready_0, e.val); end
        e = sb.pop_front(); checks++; if (32'(rd_data_0) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, rd_data_0, e.val); end
        tick();
        $display("test_commit done");
    endtask

    task automatic test_same_dest;
        clear_in();
        alloc_req_0 = 1; alloc_arf_0 = 2; ta = fl_m.pop_front();
        exp_push("sd_tag_a", ta);
        #3;
        e = sb.pop_front(); checks++; if (32'(alloc_tag_0) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, alloc_tag_0, e.val); end
        tick();
        alloc_arf_0 = 6; tb6 = fl_m.pop_front();
        tick();
        alloc_arf_0 = 2; tc = fl_m.pop_front();
        tick();
        clear_in();
        arf_valid_0 = 1; arf_dest_0 = 2; arf_value_0 = 16'h2222; commit_tag_0 = TW'(ta);
        fl_m.push_back(ta);
        tick();
        clear_in(); rd_arf_0 = 2;
        exp_push("older_commit_ready", 0); exp_push("older_commit_tag", tc);
        #3;
        e = sb.pop_front(); checks++; if (32'(rd_ready_0) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, rd_ready_0, e.val); end
        e = sb.pop_front(); checks++; if (32'(rd_tag_0) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, rd_tag_0, e.val); end
        tick();
        // Commit and allocation to the same register in one cycle.
        alloc_req_0 = 1; alloc_arf_0 = 6; td = fl_m.pop_front();
        arf_valid_0 = 1; arf_dest_0 = 6; arf_value_0 = 16'h6666; commit_tag_0 = TW'(tb6);
        fl_m.push_back(tb6);
        tick();
        clear_in(); rd_arf_0 = 6;
        exp_push("commit_alloc_ready", 0); exp_push("commit_alloc_tag", td);
        #3;
        e = sb.pop_front(); checks++; if (32'(rd_ready_0) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, rd_ready_0, e.val); end
        e = sb.pop_front(); checks++; if (32'(rd_tag_0) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, rd_tag_0, e.val); end
        tick();
        alloc_req_0 = 1; alloc_arf_0 = 7; alloc_req_1 = 1; alloc_arf_1 = 7;
        te = fl_m.pop_front(); tf = fl_m.pop_front();
        tick();
        clear_in(); rd_arf_1 = 7;
        exp_push("dual_same_arf_tag", tf);
        #3;
        e = sb.pop_front(); checks++; if (32'(rd_tag_1) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, rd_tag_1, e.val); end
        tick();
        arf_valid_0 = 1; arf_dest_0 = 2; arf_value_0 = 16'h1111; commit_tag_0 = TW'(te);
        arf_valid_1 = 1; arf_dest_1 = 2; arf_value_1 = 16'h2b2b; commit_tag_1 = TW'(tc);
        fl_m.push_back(te); fl_m.push_back(tc);
        tick();
        clear_in(); rd_arf_0 = 2;
        exp_push("dual_commit_ready", 1); exp_push("dual_commit_data", 16'h2b2b);
        exp_push("dual_commit_count", fl_m.size());
        #3;
        e = sb.pop_front(); checks++; if (32'(rd_ready_0) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, rd_ready_0, e.val); end
        e = sb.pop_front(); checks++; if (32'(rd_data_0) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, rd_data_0, e.val); end
        e = sb.pop_front(); checks++; if (32'(free_count) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, free_count, e.val); end
        tick();
        $display("test_same_dest done");
    endtask

    task automatic test_cdb_alloc_collision;
        clear_in();
        tx = fl_m.pop_front();
        alloc_req_0 = 1; alloc_arf_0 = 1;
        cdb_valid_0 = 1; cdb_tag_0 = TW'(tx); cdb_data_0 = 16'h7777;
        tick();
        clear_in(); rd_arf_0 = 1;
        exp_push("collide_ready", 0); exp_push("collide_tag", tx);
        #3;
        e = sb.pop_front(); checks++; if (32'(rd_ready_0) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, rd_ready_0, e.val); end
        e = sb.pop_front(); checks++; if (32'(rd_tag_0) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, rd_tag_0, e.val); end
        tick();
        $display("test_cdb_alloc_collision done");
    endtask

    task automatic test_back_to_back;
        clear_in();
        while (fl_m.size() > 1) begin
            alloc_req_0 = 1; alloc_arf_0 = 4;
            exp_push("b2b_tag", fl_m[0]);
            #3;
            e = sb.pop_front(); checks++; if (32'(alloc_tag_0) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, alloc_tag_0, e.val); end
            tick();
            void'(fl_m.pop_front());
        end
        alloc_req_0 = 1; alloc_req_1 = 1;
        exp_push("low_dual_gnt", 0);
        #3;
        e = sb.pop_front(); checks++; if (32'(alloc_gnt) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, alloc_gnt, e.val); end
        tick();
        clear_in();
        exp_push("low_count_kept", 1); exp_push("low_tag_kept", fl_m[0]);
        #3;
        e = sb.pop_front(); checks++; if (32'(free_count) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, free_count, e.val); end
        e = sb.pop_front(); checks++; if (32'(alloc_tag_0) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, alloc_tag_0, e.val); end
        tick();
        alloc_req_0 = 1; alloc_arf_0 = 4;
        exp_push("low_single_gnt", 1);
        #3;
        e = sb.pop_front(); checks++; if (32'(alloc_gnt) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, alloc_gnt, e.val); end
        tick();
        void'(fl_m.pop_front());
        exp_push("empty_count", 0); exp_push("empty_gnt", 0);
        #3;
        e = sb.pop_front(); checks++; if (32'(free_count) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, free_count, e.val); end
        e = sb.pop_front(); checks++; if (32'(alloc_gnt) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, alloc_gnt, e.val); end
        tick();
        clear_in();
        $display("test_back_to_back done");
    endtask

    task automatic test_overflow;
        clear_in();
        rst = 1; tick(); rst = 0;
        model_reset();
        arf_valid_0 = 1; arf_dest_0 = 1; arf_value_0 = 16'h0101; commit_tag_0 = 0;
        tick();
        clear_in(); rd_arf_0 = 1;
        exp_push("ovf_err", 1); exp_push("ovf_count", 32); exp_push("ovf_arf_value", 16'h0101);
        #3;
        e = sb.pop_front(); checks++; if (32'(fl_err) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, fl_err, e.val); end
        e = sb.pop_front(); checks++; if (32'(free_count) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, free_count, e.val); end
        e = sb.pop_front(); checks++; if (32'(rd_data_0) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, rd_data_0, e.val); end
        tick();
        $display("test_overflow done");
    endtask

    task automatic test_reset_mid;
        clear_in();
        alloc_req_0 = 1; alloc_arf_0 = 0; alloc_req_1 = 1; alloc_arf_1 = 1;
        tick();
        clear_in();
        cdb_valid_0 = 1; cdb_tag_0 = 0; cdb_data_0 = 16'h5a5a;
        rst = 1;
        #2;
        model_reset();
        exp_push("midrst_count", fl_m.size()); exp_push("midrst_err", 0); exp_push("midrst_tag0", fl_m[0]);
        e = sb.pop_front(); checks++; if (32'(free_count) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, free_count, e.val); end
        e = sb.pop_front(); checks++; if (32'(fl_err) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, fl_err, e.val); end
        e = sb.pop_front(); checks++; if (32'(alloc_tag_0) !== e.val) begin errors++; $display("FAIL %s got %0h want %0h", e.name, alloc_tag_0, e.val); end
        for (int r = 0; r < 8; r++) begin
            rd_arf_0 = 3'(r);
            exp_push("midrst_ready", 1); exp_push("midrst_data", 0);
            #1;
            e = sb.pop_front(); checks++; if (32'(rd_ready_0) !== e.val) begin errors++; $display("FAIL %s r%0d got %0h want %0h", e.name, r, rd_ready_0, e.val); end
            e = sb.pop_front(); checks++; if (32'(rd_data_0) !== e.val) begin errors++; $display("FAIL %s r%0d got %0h want %0h", e.name, r, rd_data_0, e.val); end
        end
        tick();
        clear_in();
        rst = 0;
        tick();
        $display("test_reset_mid done");
    endtask

    initial begin
        rst = 1;
        clear_in();
        test_reset();
        test_alloc_dual();
        test_cdb();
        test_commit();
        test_same_dest();
        test_cdb_alloc_collision();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
